// File: rtl/timer_pkg.sv
// Shared encodings and constants for the mm:ss timer mode controller.
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSE   = 3'd2,
        LAP     = 3'd3,
        SET_MIN = 3'd4,
        SET_SEC = 3'd5
    } state_t;

    localparam logic [7:0]  BCD_MAX_SEC = 8'h59;
    localparam logic [15:0] MAX_TIME    = 16'h5959;

endpackage

// File: rtl/bcd60_inc.sv
// Combinational BCD 00..59 incrementer; 59 (or any out-of-range value) wraps to 00.
module bcd60_inc
    import timer_pkg::*;
(
    input  logic [7:0] val,
    output logic [7:0] val_inc
);

    always_comb begin
        val_inc = '0;
        if (val >= BCD_MAX_SEC || val[7:4] > 4'd5) begin
            val_inc = '0;
        end else if (val[3:0] >= 4'd9) begin
            val_inc = {val[7:4] + 4'd1, 4'd0};
        end else begin
            val_inc = {val[7:4], val[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/timer_ctrl_fsm.sv
// Run/Pause/Lap/Set mode controller for the mm:ss BCD counter: key edge
// detection, counter enable/load, display mux, blink and end-of-range alarm.
module timer_ctrl_fsm
    import timer_pkg::*;
#(
    parameter int          STOP_AT_MAX = 1,
    parameter int unsigned ALARM_LEN   = 5
) (
    input  logic        clk_1hz,
    input  logic        reset,
    input  logic        key_start,
    input  logic        key_mode,
    input  logic        key_inc,
    input  logic [15:0] cnt_digits,
    output logic        cnt_enable,
    output logic        cnt_load,
    output logic [15:0] load_digits,
    output logic [15:0] disp_digits,
    output logic [3:0]  blink_mask,
    output logic        alarm,
    output logic [2:0]  state_dbg
);

    localparam logic [3:0] ALARM_INIT = 4'(ALARM_LEN);

    state_t      state;
    logic        key_start_q;
    logic        key_mode_q;
    logic        key_inc_q;
    logic [3:0]  alarm_cnt;
    logic        blink_phase;
    logic [15:0] edit_reg;
    logic [15:0] lap_reg;

    logic        ev_start;
    logic        ev_mode;
    logic        ev_inc;
    logic        at_max;
    logic        counting;
    logic        in_set;
    logic [7:0]  min_next;
    logic [7:0]  sec_next;

    // Only the highest-priority press of a cycle survives (start > mode > inc).
    always_comb begin
        ev_start = key_start & ~key_start_q;
        ev_mode  = key_mode & ~key_mode_q & ~ev_start;
        ev_inc   = key_inc & ~key_inc_q & ~ev_start & ~ev_mode;
    end

    always_comb begin
        counting = (state == RUN) || (state == LAP);
        in_set   = (state == SET_MIN) || (state == SET_SEC);
        at_max   = (STOP_AT_MAX != 0) && (cnt_digits == MAX_TIME);
    end

    bcd60_inc u_min_inc (
        .val     (edit_reg[15:8]),
        .val_inc (min_next)
    );

    bcd60_inc u_sec_inc (
        .val     (edit_reg[7:0]),
        .val_inc (sec_next)
    );

    always_ff @(posedge clk_1hz or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            key_start_q <= 1'b0;
            key_mode_q  <= 1'b0;
            key_inc_q   <= 1'b0;
            cnt_load    <= 1'b0;
            alarm_cnt   <= '0;
            blink_phase <= 1'b0;
            edit_reg    <= '0;
            lap_reg     <= '0;
        end else begin
            key_start_q <= key_start;
            key_mode_q  <= key_mode;
            key_inc_q   <= key_inc;
            cnt_load    <= 1'b0;
            blink_phase <= in_set ? ~blink_phase : 1'b0;
            if (alarm_cnt != '0) begin
                alarm_cnt <= alarm_cnt - 4'd1;
            end

            // Reaching 59:59 while counting overrides any key event that cycle.
            if (counting && at_max) begin
                state     <= IDLE;
                alarm_cnt <= ALARM_INIT;
            end else begin
                case (state)
                    IDLE: begin
                        if (ev_start) begin
                            if (alarm_cnt != '0) begin
                                alarm_cnt <= '0;
                            end else begin
                                state <= RUN;
                            end
                        end else if (ev_mode) begin
                            state    <= SET_MIN;
                            edit_reg <= cnt_digits;
                        end
                    end
                    RUN: begin
                        if (ev_start) begin
                            state <= PAUSE;
                        end else if (ev_mode) begin
                            state   <= LAP;
                            lap_reg <= cnt_digits;
                        end
                    end
                    LAP: begin
                        if (ev_start) begin
                            state <= PAUSE;
                        end else if (ev_mode) begin
                            state <= RUN;
                        end
                    end
                    PAUSE: begin
                        if (ev_start) begin
                            state <= RUN;
                        end else if (ev_mode) begin
                            state <= IDLE;
                        end
                    end
                    SET_MIN: begin
                        if (ev_mode) begin
                            state <= SET_SEC;
                        end else if (ev_inc) begin
                            edit_reg[15:8] <= min_next;
                        end
                    end
                    SET_SEC: begin
                        if (ev_mode) begin
                            state    <= IDLE;
                            cnt_load <= 1'b1;
                        end else if (ev_inc) begin
                            edit_reg[7:0] <= sec_next;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        cnt_enable  = counting && !at_max;
        alarm       = (alarm_cnt != '0);
        load_digits = edit_reg;
        state_dbg   = state;

        disp_digits = cnt_digits;
        if (state == LAP) begin
            disp_digits = lap_reg;
        end else if (in_set) begin
            disp_digits = edit_reg;
        end

        blink_mask = '0;
        if (state == SET_MIN) begin
            blink_mask = {{2{blink_phase}}, 2'b00};
        end else if (state == SET_SEC) begin
            blink_mask = {2'b00, {2{blink_phase}}};
        end
    end

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Directed self-checking bench for timer_ctrl_fsm with hand-computed expectations.
module tb_timer_ctrl_fsm;

    logic        clk_1hz = 1'b0;
    logic        reset   = 1'b1;
    logic        key_start = 1'b0;
    logic        key_mode  = 1'b0;
    logic        key_inc   = 1'b0;
    logic [15:0] cnt_digits = 16'h0000;
    logic        cnt_enable;
    logic        cnt_load;
    logic [15:0] load_digits;
    logic [15:0] disp_digits;
    logic [3:0]  blink_mask;
    logic        alarm;
    logic [2:0]  state_dbg;

    int unsigned checks = 0;
    int unsigned errors = 0;

    timer_ctrl_fsm #(
        .STOP_AT_MAX (1),
        .ALARM_LEN   (5)
    ) dut (
        .clk_1hz     (clk_1hz),
        .reset       (reset),
        .key_start   (key_start),
        .key_mode    (key_mode),
        .key_inc     (key_inc),
        .cnt_digits  (cnt_digits),
        .cnt_enable  (cnt_enable),
        .cnt_load    (cnt_load),
        .load_digits (load_digits),
        .disp_digits (disp_digits),
        .blink_mask  (blink_mask),
        .alarm       (alarm),
        .state_dbg   (state_dbg)
    );

    always #5 clk_1hz = ~clk_1hz;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1hz);
        #1;
    endtask

    // 0=start, 1=mode, 2=inc; key high across exactly one active edge.
    task automatic press(input int unsigned which);
        case (which)
            0: key_start = 1'b1;
            1: key_mode  = 1'b1;
            default: key_inc = 1'b1;
        endcase
        tick();
        key_start = 1'b0;
        key_mode  = 1'b0;
        key_inc   = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_state", 16'(state_dbg), 16'd0);
        check("rst_enable", 16'(cnt_enable), 16'd0);
        check("rst_load", 16'(cnt_load), 16'd0);
        check("rst_alarm", 16'(alarm), 16'd0);
        check("rst_blink", 16'(blink_mask), 16'd0);
        check("rst_loaddig", load_digits, 16'h0000);
        reset = 1'b0;
        tick();

        // Start / stop
        press(0);
        check("start_run", 16'(state_dbg), 16'd1);
        check("run_enable", 16'(cnt_enable), 16'd1);
        tick();
        press(0);
        check("start_pause", 16'(state_dbg), 16'd2);
        check("pause_enable", 16'(cnt_enable), 16'd0);
        tick();
        press(2);
        check("pause_inc_ign", 16'(state_dbg), 16'd2);
        tick();
        press(1);
        check("pause_idle", 16'(state_dbg), 16'd0);
        tick();

        // Lap hold
        cnt_digits = 16'h0123;
        press(0);
        check("lap_run", 16'(state_dbg), 16'd1);
        tick();
        press(1);
        check("lap_state", 16'(state_dbg), 16'd3);
        cnt_digits = 16'h0130;
        #1;
        check("lap_disp_held", disp_digits, 16'h0123);
        check("lap_enable", 16'(cnt_enable), 16'd1);
        tick();
        press(1);
        check("lap_back_run", 16'(state_dbg), 16'd1);
        check("run_disp_live", disp_digits, 16'h0130);
        cnt_digits = 16'h0131;
        #1;
        check("run_disp_follow", disp_digits, 16'h0131);
        tick();
        press(1);
        check("lap_again", 16'(state_dbg), 16'd3);
        tick();
        press(0);
        check("lap_to_pause", 16'(state_dbg), 16'd2);
        check("pause_disp", disp_digits, 16'h0131);
        tick();
        press(1);
        check("pause_to_idle", 16'(state_dbg), 16'd0);
        tick();

        // Set mode edit
        cnt_digits = 16'h0958;
        press(1);
        check("set_min", 16'(state_dbg), 16'd4);
        check("set_min_disp", disp_digits, 16'h0958);
        check("set_min_blink0", 16'(blink_mask), 16'h0);
        tick();
        check("set_min_blink1", 16'(blink_mask), 16'hC);
        press(0);
        check("set_start_ign", 16'(state_dbg), 16'd4);
        tick();
        for (int i = 0; i < 50; i++) begin
            press(2);
            tick();
        end
        check("min_59", disp_digits, 16'h5958);
        press(2);
        tick();
        check("min_wrap", disp_digits, 16'h0058);
        press(1);
        check("set_sec", 16'(state_dbg), 16'd5);
        check("set_sec_blink0", 16'(blink_mask), 16'h0);
        tick();
        check("set_sec_blink1", 16'(blink_mask), 16'h3);
        for (int i = 0; i < 3; i++) begin
            press(2);
            tick();
        end
        check("sec_wrap", disp_digits, 16'h0001);
        check("sec_no_load", 16'(cnt_load), 16'd0);
        press(1);
        check("set_done_idle", 16'(state_dbg), 16'd0);
        check("load_strobe", 16'(cnt_load), 16'd1);
        check("load_value", load_digits, 16'h0001);
        check("idle_blink", 16'(blink_mask), 16'h0);
        tick();
        check("load_one_cycle", 16'(cnt_load), 16'd0);

        // Stop at 59:59 with alarm
        cnt_digits = 16'h5958;
        press(0);
        check("max_run", 16'(state_dbg), 16'd1);
        cnt_digits = 16'h5959;
        #1;
        check("max_enable_off", 16'(cnt_enable), 16'd0);
        tick();
        check("max_idle", 16'(state_dbg), 16'd0);
        for (int i = 0; i < 5; i++) begin
            check("alarm_on", 16'(alarm), 16'd1);
            tick();
        end
        check("alarm_off", 16'(alarm), 16'd0);
        press(0);
        check("max_rerun", 16'(state_dbg), 16'd1);
        tick();
        check("max_idle2", 16'(state_dbg), 16'd0);
        check("alarm_on2", 16'(alarm), 16'd1);
        tick();
        press(0);
        check("alarm_clear", 16'(alarm), 16'd0);
        check("alarm_stay_idle", 16'(state_dbg), 16'd0);
        tick();

        // Simultaneous keys and held key
        cnt_digits = 16'h0000;
        key_start = 1'b1;
        key_mode  = 1'b1;
        tick();
        check("prio_run", 16'(state_dbg), 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_single", 16'(state_dbg), 16'd1);
        end
        key_start = 1'b0;
        key_mode  = 1'b0;
        tick();
        check("held_release", 16'(state_dbg), 16'd1);
        press(0);
        check("held_pause", 16'(state_dbg), 16'd2);
        tick();
        press(1);
        check("held_idle", 16'(state_dbg), 16'd0);
        tick();

        // Asynchronous reset from SET_SEC with pending edit
        press(1);
        tick();
        press(1);
        tick();
        press(2);
        check("pre_rst_state", 16'(state_dbg), 16'd5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_state", 16'(state_dbg), 16'd0);
        check("arst_load", 16'(cnt_load), 16'd0);
        check("arst_blink", 16'(blink_mask), 16'h0);
        check("arst_alarm", 16'(alarm), 16'd0);
        check("arst_edit", load_digits, 16'h0000);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_state", 16'(state_dbg), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
